// File: rtl/backbone_pkg.sv
// Shared backbone types and widths used by the conv1 drain stage and its FIFO.
package backbone_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  localparam int CONV1_DRAIN_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } conv1_drain_state_t;

endpackage

// File: rtl/conv1_drain_fifo.sv
// Two-entry synchronous FIFO holding {addr, data} words for the conv1 drain output port.
module conv1_drain_fifo
  import backbone_pkg::*;
#(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL = 2'(CONV1_DRAIN_FIFO_DEPTH);

  logic [WIDTH-1:0] mem [CONV1_DRAIN_FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != 2'd0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & ((count != FULL) | do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the two entries are reset so the output port reads 0 after reset, not X.
      for (int i = 0; i < CONV1_DRAIN_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/conv1_requant_relu_drain.sv
// Conv1 post-GEMM drain: reads accumulators, adds bias, rounds/shifts, ReLU, saturates and
// streams channel-major. Optional statistics counters when CONV1_DRAIN_STATS_EN is defined.
module conv1_requant_relu_drain
  import backbone_pkg::*;
#(
  parameter int M_TOTAL  = 56*56,
  parameter int N_TOTAL  = 64,
  parameter int DATA_W_P = DATA_W,
  parameter int ACC_W_P  = ACC_W,
  parameter int SHIFT_W  = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [SHIFT_W-1:0]                cfg_shift,
  input  logic [N_TOTAL-1:0][ACC_W_P-1:0]   bias_i,
  output logic                              busy,
  output logic                              done,
  output logic                              c_rd_en,
  output int                                c_rd_addr,
  input  logic [ACC_W_P-1:0]                c_rd_data,
  output logic                              o_valid,
  input  logic                              o_ready,
  output int                                o_addr,
  output logic [DATA_W_P-1:0]               o_data
`ifdef CONV1_DRAIN_STATS_EN
  ,
  output logic [31:0]                       stat_relu_cnt,
  output logic [31:0]                       stat_sat_cnt
`endif
);

  localparam int MW = (M_TOTAL > 1) ? $clog2(M_TOTAL) : 1;
  localparam int NW = (N_TOTAL > 1) ? $clog2(N_TOTAL) : 1;
  localparam logic [MW-1:0] M_LAST = MW'(M_TOTAL - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_TOTAL - 1);
  // Two bits of headroom: one for bias add, one for the rounding increment.
  localparam int SW = ACC_W_P + 2;
  localparam int FW = 32 + DATA_W_P;
  localparam logic signed [SW-1:0] D_MAX = (SW'(1) <<< (DATA_W_P - 1)) - SW'(1);
  localparam logic [2:0] FIFO_CAP = 3'(CONV1_DRAIN_FIFO_DEPTH);

  function automatic logic signed [SW-1:0] requant_pre(
    input logic signed [ACC_W_P-1:0] acc,
    input logic signed [ACC_W_P-1:0] bias,
    input logic [SHIFT_W-1:0]        sh
  );
    logic signed [SW-1:0] s;
    s = SW'(acc) + SW'(bias);
    if (sh != '0) begin
      s = s + (SW'(1) <<< (sh - SHIFT_W'(1)));
      s = s >>> sh;
    end
    return s;
  endfunction

  function automatic logic [DATA_W_P-1:0] requant_clip(input logic signed [SW-1:0] s);
    if (s[SW-1])      return '0;
    else if (s > D_MAX) return {1'b0, {(DATA_W_P-1){1'b1}}};
    else              return s[DATA_W_P-1:0];
  endfunction

  conv1_drain_state_t state, state_n;

  logic [MW-1:0]        m_cnt;
  logic [NW-1:0]        n_cnt;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 inflight;
  int                   inflight_addr;
  logic [NW-1:0]        inflight_n;
  logic [1:0]           fifo_count;
  logic                 fifo_valid;
  logic [FW-1:0]        fifo_rdata;
  logic                 pop;
  logic                 issue;
  logic                 start_ok;
  logic                 last_rd;
  logic signed [SW-1:0] pre_s;
  logic [DATA_W_P-1:0]  push_data;

  assign start_ok = (state == S_IDLE) && start;
  assign pop      = fifo_valid & o_ready;
  assign last_rd  = (m_cnt == M_LAST) && (n_cnt == N_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    state_n = state;
    issue   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN: begin
        // Reserve a FIFO slot for every read in flight; a pop this cycle frees one.
        issue = ({1'b0, fifo_count} + {2'b0, inflight}) < (FIFO_CAP + {2'b0, pop});
        if (issue && last_rd) state_n = S_FLUSH;
      end
      S_FLUSH: if (!inflight && fifo_count == 2'd0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt         <= '0;
      n_cnt         <= '0;
      shift_q       <= '0;
      inflight      <= 1'b0;
      inflight_addr <= 0;
      inflight_n    <= '0;
    end else begin
      inflight <= issue;
      if (start_ok) begin
        m_cnt   <= '0;
        n_cnt   <= '0;
        shift_q <= cfg_shift;
      end else if (issue) begin
        inflight_addr <= int'(n_cnt) * M_TOTAL + int'(m_cnt);
        inflight_n    <= n_cnt;
        if (n_cnt == N_LAST) begin
          n_cnt <= '0;
          m_cnt <= last_rd ? '0 : m_cnt + MW'(1);
        end else begin
          n_cnt <= n_cnt + NW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              done <= 1'b0;
    else if (start_ok)       done <= 1'b0;
    else if (state == S_DONE) done <= 1'b1;
  end

  assign busy      = (state == S_RUN) || (state == S_FLUSH);
  assign c_rd_en   = issue;
  assign c_rd_addr = int'(m_cnt) * N_TOTAL + int'(n_cnt);

  assign pre_s     = requant_pre(c_rd_data, bias_i[inflight_n], shift_q);
  assign push_data = requant_clip(pre_s);

  conv1_drain_fifo #(.WIDTH(FW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata ({inflight_addr, push_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign o_valid = fifo_valid;
  assign o_addr  = int'(fifo_rdata[FW-1:DATA_W_P]);
  assign o_data  = fifo_rdata[DATA_W_P-1:0];

`ifdef CONV1_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_relu_cnt <= '0;
      stat_sat_cnt  <= '0;
    end else if (start_ok) begin
      stat_relu_cnt <= '0;
      stat_sat_cnt  <= '0;
    end else if (inflight) begin
      if (pre_s[SW-1])  stat_relu_cnt <= stat_relu_cnt + 32'd1;
      if (pre_s > D_MAX) stat_sat_cnt <= stat_sat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv1_requant_relu_drain.sv
// Self-checking bench for conv1_requant_relu_drain (M_TOTAL=4, N_TOTAL=2, DATA_W=8, ACC_W=32).
module tb_conv1_requant_relu_drain;

  localparam int M = 4;
  localparam int N = 2;
  localparam int E = M * N;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [4:0]        cfg_shift;
  logic [N-1:0][31:0] bias_i;
  logic              busy;
  logic              done;
  logic              c_rd_en;
  int                c_rd_addr;
  logic [31:0]       c_rd_data;
  logic              o_valid;
  logic              o_ready;
  int                o_addr;
  logic [7:0]        o_data;
`ifdef CONV1_DRAIN_STATS_EN
  logic [31:0]       stat_relu_cnt;
  logic [31:0]       stat_sat_cnt;
`endif

  conv1_requant_relu_drain #(
    .M_TOTAL (M),
    .N_TOTAL (N),
    .DATA_W_P(8),
    .ACC_W_P (32),
    .SHIFT_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_shift (cfg_shift),
    .bias_i    (bias_i),
    .busy      (busy),
    .done      (done),
    .c_rd_en   (c_rd_en),
    .c_rd_addr (c_rd_addr),
    .c_rd_data (c_rd_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_addr    (o_addr),
    .o_data    (o_data)
`ifdef CONV1_DRAIN_STATS_EN
    ,
    .stat_relu_cnt (stat_relu_cnt),
    .stat_sat_cnt  (stat_sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   c_mem [E];
  int   bias_v [N];
  int   shift_v;
  logic [7:0] obs_data [E];
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } word_t;

  // C BRAM: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (c_rd_en) c_rd_data <= c_mem[c_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer math in 64 bits, then ReLU and clip to int8 max.
  function automatic logic [7:0] ref_requant(input int c, input int b, input int sh,
                                             output bit relu, output bit sat);
    longint s;
    s = longint'(c) + longint'(b);
    if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
    relu = (s < 0);
    sat  = (s > 127);
    if (s < 0)        return 8'd0;
    else if (s > 127) return 8'd127;
    else              return 8'(s);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < E; i++) c_mem[i] = int'($urandom) >>> $urandom_range(28, 8);
    for (int n = 0; n < N; n++) bias_v[n] = int'($urandom) >>> $urandom_range(30, 14);
    shift_v = int'($urandom_range(12, 0));
  endtask

  task automatic run_drain(input string tag, input int low_pct, input int poke_at,
                           input bit check_b2b);
    word_t q[$];
    word_t w;
    int    cyc, first_pop, last_pop, rises, relu_e, sat_e;
    bit    prev_stall, prev_done, r, s;
    logic [7:0] held_d;
    int    held_a;

    relu_e = 0;
    sat_e  = 0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        w.addr = n * M + m;
        w.data = ref_requant(c_mem[m * N + n], bias_v[n], shift_v, r, s);
        relu_e += int'(r);
        sat_e  += int'(s);
        q.push_back(w);
      end
    end
    for (int i = 0; i < E; i++) obs_data[i] = 8'hxx;
    cfg_shift = 5'(shift_v);
    for (int n = 0; n < N; n++) bias_i[n] = bias_v[n];

    o_ready = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":done_clr"}, 64'(done), 64'd0);
    check({tag, ":busy"}, 64'(busy), 64'd1);

    cyc = 0; first_pop = -1; last_pop = -1; rises = 0;
    prev_stall = 1'b0; prev_done = 1'b0; held_d = '0; held_a = 0;
    while (cyc < 400) begin
      start = (cyc == poke_at);
      if (prev_stall) begin
        check({tag, ":valid_held"}, 64'(o_valid), 64'd1);
        check({tag, ":data_held"}, 64'(o_data), 64'(held_d));
        check({tag, ":addr_held"}, 64'(o_addr), 64'(held_a));
      end
      check({tag, ":fifo_le2"}, 64'(dut.fifo_count <= 2'd2), 64'd1);
      o_ready = ($urandom_range(99, 0) >= low_pct);
      if (o_valid && o_ready) begin
        if (q.size() == 0) begin
          check({tag, ":extra_word"}, 64'(o_addr), 64'hFFFF_FFFF);
        end else begin
          w = q.pop_front();
          check({tag, ":o_addr"}, 64'(o_addr), 64'(w.addr));
          check({tag, ":o_data"}, 64'(o_data), 64'(w.data));
          if (o_addr >= 0 && o_addr < E) obs_data[o_addr] = o_data;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
      prev_stall = o_valid && !o_ready;
      held_d = o_data;
      held_a = o_addr;
      if (done && !prev_done) rises++;
      prev_done = done;
      if (done && q.size() == 0) break;
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    o_ready = 1'b1;
    check({tag, ":finished"}, 64'(done && (q.size() == 0)), 64'd1);
    check({tag, ":done_once"}, 64'(rises), 64'd1);
    if (check_b2b) check({tag, ":b2b_span"}, 64'(last_pop - first_pop), 64'(E - 1));
    repeat (3) begin
      @(negedge clk);
      check({tag, ":no_extra"}, 64'(o_valid), 64'd0);
    end
    check({tag, ":done_sticky"}, 64'(done), 64'd1);
    check({tag, ":idle"}, 64'(busy), 64'd0);
`ifdef CONV1_DRAIN_STATS_EN
    check({tag, ":relu_cnt"}, 64'(stat_relu_cnt), 64'(relu_e));
    check({tag, ":sat_cnt"}, 64'(stat_sat_cnt), 64'(sat_e));
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ":o_valid"}, 64'(o_valid), 64'd0);
    check({tag, ":busy"}, 64'(busy), 64'd0);
    check({tag, ":done"}, 64'(done), 64'd0);
    check({tag, ":c_rd_en"}, 64'(c_rd_en), 64'd0);
    check({tag, ":c_rd_addr"}, 64'(c_rd_addr), 64'd0);
    check({tag, ":o_addr"}, 64'(o_addr), 64'd0);
    check({tag, ":o_data"}, 64'(o_data), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    o_ready   = 1'b0;
    cfg_shift = '0;
    bias_i    = '0;
    fill_random();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Rounding shift, full-rate drain.
    fill_random();
    c_mem[0] = 100; bias_v[0] = 0; shift_v = 2;
    run_drain("dirA", 0, -1, 1'b1);
    check("dirA:value", 64'(obs_data[0]), 64'd25);

    // Saturation under back-pressure.
    fill_random();
    c_mem[0] = 1000; bias_v[0] = 24; shift_v = 3;
    run_drain("dirB", 30, -1, 1'b0);
    check("dirB:value", 64'(obs_data[0]), 64'd127);

    // ReLU with no shift.
    fill_random();
    c_mem[0] = -50; bias_v[0] = 10; shift_v = 0;
    run_drain("dirC", 30, -1, 1'b0);
    check("dirC:value", 64'(obs_data[0]), 64'd0);

    // Headroom: sum exceeds int32, must not wrap.
    fill_random();
    c_mem[0] = 32'h7FFF_FFFF; bias_v[0] = 1; shift_v = 31;
    run_drain("dirD", 0, -1, 1'b1);
    check("dirD:value", 64'(obs_data[0]), 64'd1);

    // Random runs with back-pressure and a start pulse while busy.
    for (int k = 0; k < 4; k++) begin
      fill_random();
      run_drain($sformatf("rnd%0d", k), 30, 3 + k, 1'b0);
    end

    // Abort mid-run, then a clean restart.
    fill_random();
    cfg_shift = 5'(shift_v);
    for (int n = 0; n < N; n++) bias_i[n] = bias_v[n];
    o_ready = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst:still_idle", 64'(o_valid), 64'd0);
    fill_random();
    run_drain("restart", 30, -1, 1'b0);
    fill_random();
    run_drain("restart_full", 0, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
